// File: rtl/bb_phase_detector_acc.sv
// bb_phase_detector_acc: Alexander bang-bang phase detector with a
// thresholded vote accumulator producing CDR up/down pulses.
module bb_phase_detector_acc #(
    parameter int CNT_W = 6,
    parameter int ACC_W = 5,
    parameter int THR   = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_phase,
    input  logic [CNT_W-1:0] i_nb_P,
    input  logic             i_acc_clr,
    output logic             o_T,
    output logic             o_E,
    output logic             o_valid,
    output logic             o_up,
    output logic             o_dn,
    output logic [ACC_W-1:0] o_acc
);

    if (THR < 1 || THR > (2 ** (ACC_W - 1)) - 1) begin : g_thr_chk
        $error("THR must be in 1..2^(ACC_W-1)-1");
    end

    localparam logic [ACC_W:0] THR_P = (ACC_W + 1)'(THR);
    localparam logic [ACC_W:0] THR_N = ~THR_P + 1'b1;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] per;
    logic [CNT_W-1:0] per_in;
    logic [CNT_W-1:0] half;
    logic             m;
    logic             d_prev;
    logic             primed;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   vote;
    logic [ACC_W:0]   nxt;
    logic             wrap;
    logic             eval;
    logic             t_new;
    logic             e_new;

    assign per_in = (i_nb_P < CNT_W'(2)) ? CNT_W'(2) : i_nb_P;
    assign half   = per >> 1;
    assign wrap   = (cnt == per - 1'b1);
    assign eval   = (cnt == '0) && primed;
    assign t_new  = d_prev ^ i_phase;
    assign e_new  = d_prev ^ m;
    assign o_acc  = acc;

    always_comb begin
        vote = '0;
        if (eval && t_new) begin
            vote = e_new ? (ACC_W + 1)'(1) : '1;
        end
        nxt = {acc[ACC_W-1], acc} + vote;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            cnt     <= '0;
            per     <= CNT_W'(2);
            m       <= 1'b0;
            d_prev  <= 1'b0;
            primed  <= 1'b0;
            o_T     <= 1'b0;
            o_E     <= 1'b0;
            o_valid <= 1'b0;
            o_up    <= 1'b0;
            o_dn    <= 1'b0;
            acc     <= '0;
        end else begin
            o_valid <= 1'b0;
            o_up    <= 1'b0;
            o_dn    <= 1'b0;
            cnt     <= wrap ? '0 : cnt + 1'b1;
            // first edge after reset takes its period directly from the port
            if (wrap || (cnt == '0 && !primed)) begin
                per <= per_in;
            end
            if (cnt == half) begin
                m <= i_phase;
            end
            if (cnt == '0) begin
                d_prev <= i_phase;
                primed <= 1'b1;
            end
            if (eval) begin
                o_valid <= 1'b1;
                o_T     <= t_new;
                o_E     <= e_new;
            end
            if (i_acc_clr) begin
                acc <= '0;
            end else if (nxt == THR_P) begin
                acc  <= '0;
                o_up <= 1'b1;
            end else if (nxt == THR_N) begin
                acc  <= '0;
                o_dn <= 1'b1;
            end else begin
                acc <= nxt[ACC_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_bb_phase_detector_acc.sv
// Bench for bb_phase_detector_acc: directed phases plus random stimulus
// checked against a symbol-timeline reference model.
module tb_bb_phase_detector_acc;

    localparam int CNT_W = 6;
    localparam int ACC_W = 5;
    localparam int THR   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             phase;
    logic [CNT_W-1:0] nb;
    logic             clr;
    logic             o_T;
    logic             o_E;
    logic             o_valid;
    logic             o_up;
    logic             o_dn;
    logic [ACC_W-1:0] o_acc;

    int checks = 0;
    int errors = 0;

    // reference model: symbol start times on an absolute cycle axis
    bit rs = 1'b1;
    int t, start, per;
    bit primed_m, dprev_m, mid_m;
    bit eV, eT, eE, eUp, eDn;
    int eAcc;

    int mode;
    bit lvl;
    int ups, dns, mups;

    always #10 clk = ~clk;

    bb_phase_detector_acc #(
        .CNT_W(CNT_W),
        .ACC_W(ACC_W),
        .THR  (THR)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_phase  (phase),
        .i_nb_P   (nb),
        .i_acc_clr(clr),
        .o_T      (o_T),
        .o_E      (o_E),
        .o_valid  (o_valid),
        .o_up     (o_up),
        .o_dn     (o_dn),
        .o_acc    (o_acc)
    );

    function automatic int eff(int n);
        return (n < 2) ? 2 : n;
    endfunction

    task automatic chk(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int vote;
        int n;
        if (!rst) begin
            rs = 1'b1; primed_m = 1'b0; dprev_m = 1'b0; mid_m = 1'b0;
            eV = 0; eT = 0; eE = 0; eUp = 0; eDn = 0; eAcc = 0;
            return;
        end
        if (rs) begin
            rs = 1'b0; t = 0; start = 0; per = eff(int'(nb));
        end
        eV = 0; eUp = 0; eDn = 0; vote = 0;
        if (t == start) begin
            if (primed_m) begin
                eV = 1;
                eT = dprev_m ^ phase;
                eE = dprev_m ^ mid_m;
                if (eT) vote = eE ? 1 : -1;
            end
            dprev_m = phase;
            primed_m = 1'b1;
        end
        if (t == start + per / 2) mid_m = phase;
        if (t == start + per - 1) begin
            start += per;
            per = eff(int'(nb));
        end
        if (clr) begin
            eAcc = 0;
        end else begin
            n = eAcc + vote;
            if (n == THR) begin
                eUp = 1; eAcc = 0;
            end else if (n == -THR) begin
                eDn = 1; eAcc = 0;
            end else begin
                eAcc = n;
            end
        end
        t++;
    endtask

    task automatic cyc();
        int pos;
        logic [9:0] obs;
        logic [9:0] exp;
        logic [4:0] a5;
        pos = rs ? 0 : t - start;
        case (mode)
            1: begin if (pos == 2) lvl = ~lvl; phase = lvl; end
            2: begin if (pos == 6) lvl = ~lvl; phase = lvl; end
            3: phase = 1'b1;
            default: phase = 1'($urandom);
        endcase
        @(posedge clk);
        model_edge();
        #1;
        a5 = eAcc[4:0];
        obs = {o_valid, o_T, o_E, o_up, o_dn, o_acc};
        exp = {eV, eT, eE, eUp, eDn, a5};
        chk("outs", int'(obs), int'(exp));
        chk("up_dn_excl", int'(o_up & o_dn), 0);
        chk("pulse_wo_valid", int'((o_up | o_dn) & ~o_valid), 0);
        if (o_up) ups++;
        if (o_dn) dns++;
        if (eUp) mups++;
    endtask

    initial begin
        int first, nv, g;
        bit found;
        rst = 1'b0; nb = 8; clr = 1'b0; phase = 1'b0; mode = 0; lvl = 1'b0;

        repeat (5) cyc();
        chk("rst_zero", int'({o_valid, o_T, o_E, o_up, o_dn, o_acc}), 0);

        rst = 1'b1;
        first = -1;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (o_valid && first < 0) first = i;
        end
        chk("first_valid_cycle", first, 9);

        mode = 1;
        repeat (16) cyc();
        ups = 0; dns = 0; mups = 0;
        for (int i = 0; i < 128; i++) begin
            cyc();
            if (o_valid) chk("late_TE", int'({o_T, o_E}), 3);
        end
        chk("late_no_dn", dns, 0);
        chk("late_ups", ups, mups);
        chk("late_ups_min", int'(ups >= 3), 1);

        mode = 2;
        repeat (16) cyc();
        ups = 0; dns = 0;
        for (int i = 0; i < 128; i++) begin
            cyc();
            if (o_valid) chk("early_TE", int'({o_T, o_E}), 2);
        end
        chk("early_no_up", ups, 0);
        chk("early_dns_min", int'(dns >= 3), 1);

        mode = 3;
        repeat (16) cyc();
        ups = 0; dns = 0; nv = 0;
        for (int i = 0; i < 160; i++) begin
            cyc();
            if (o_valid) begin
                nv++;
                chk("const_T", int'(o_T), 0);
            end
        end
        chk("const_valid_cnt", nv, 20);
        chk("const_no_pulse", ups + dns, 0);

        mode = 1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (!rs && primed_m && t == start && eAcc == 3) found = 1'b1;
            else cyc();
        end
        chk("clr_reach", int'(found), 1);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        chk("clr_acc", int'(o_acc), 0);
        chk("clr_no_up", int'(o_up), 0);
        chk("clr_valid", int'(o_valid), 1);
        chk("clr_T", int'(o_T), 1);

        mode = 0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (!rs && per == 8 && t - start == 3) found = 1'b1;
            else cyc();
        end
        chk("p_change_reach", int'(found), 1);
        nb = 2;
        first = -1;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            if (o_valid && first < 0) begin
                first = i;
                break;
            end
        end
        chk("p8_complete", first, 6);
        for (int k = 0; k < 4; k++) begin
            g = -1;
            for (int j = 1; j <= 10; j++) begin
                cyc();
                if (o_valid) begin g = j; break; end
            end
            chk("p2_gap", g, 2);
        end
        nb = 1;
        repeat (4) cyc();
        for (int k = 0; k < 4; k++) begin
            g = -1;
            for (int j = 1; j <= 10; j++) begin
                cyc();
                if (o_valid) begin g = j; break; end
            end
            chk("p1_gap", g, 2);
        end

        for (int i = 0; i < 1500; i++) begin
            if (i % 7 == 0) nb = CNT_W'($urandom_range(0, 12));
            clr = ($urandom_range(0, 7) == 0);
            cyc();
        end
        clr = 1'b0;

        nb = 8;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (!rs && per == 8 && t - start == 3) found = 1'b1;
            else cyc();
        end
        chk("mid_rst_reach", int'(found), 1);
        rst = 1'b0;
        cyc();
        chk("mid_rst_zero", int'({o_valid, o_T, o_E, o_up, o_dn, o_acc}), 0);
        rst = 1'b1;
        first = -1;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (o_valid && first < 0) first = i;
        end
        chk("reprime_first", first, 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
